// File: rtl/instr_executor_if.sv
// rtl/instr_executor_if.sv - handshake, register-file, memory and PC ports of instr_executor
interface instr_executor_if;
   logic [31:0] instr;
   logic [31:0] pc;
   logic        run;
   logic        ok;
   logic [4:0]  reg_raddr;
   logic [31:0] reg_rdata;
   logic [4:0]  reg_waddr;
   logic [31:0] reg_wdata;
   logic        reg_wren;
   logic [16:0] mem_raddr;
   logic [31:0] mem_rdata;
   logic [16:0] mem_waddr;
   logic [31:0] mem_wdata;
   logic        mem_wren;
   logic [31:0] pc_wdata;
   logic        pc_wren;

   modport master (
      output instr, pc, run, reg_rdata, mem_rdata,
      input  ok, reg_raddr, reg_waddr, reg_wdata, reg_wren,
             mem_raddr, mem_waddr, mem_wdata, mem_wren, pc_wdata, pc_wren
   );

   modport slave (
      input  instr, pc, run, reg_rdata, mem_rdata,
      output ok, reg_raddr, reg_waddr, reg_wdata, reg_wren,
             mem_raddr, mem_waddr, mem_wdata, mem_wren, pc_wdata, pc_wren
   );
endinterface

// File: rtl/instr_executor.sv
// rtl/instr_executor.sv - multi-cycle executor for one latched instruction per run/ok handshake
// Optional macro INSTR_EXEC_ILLEGAL_TRAP_EN adds the sticky illegal output and suppresses writes for undefined opcodes.
module instr_executor (
   input  logic clk,
   input  logic rst,
`ifdef INSTR_EXEC_ILLEGAL_TRAP_EN
   output logic illegal,
`endif
   instr_executor_if.slave bus
);
   typedef enum logic [2:0] {
      S_IDLE, S_RD_A, S_RD_B, S_EXEC, S_MEM, S_MEM_W, S_WB, S_DONE
   } state_t;

   localparam logic [5:0] OP_ADD  = 6'h01;
   localparam logic [5:0] OP_SUB  = 6'h02;
   localparam logic [5:0] OP_ADDI = 6'h03;
   localparam logic [5:0] OP_LW   = 6'h04;
   localparam logic [5:0] OP_SW   = 6'h05;
   localparam logic [5:0] OP_BEQ  = 6'h06;
   localparam logic [5:0] OP_JMP  = 6'h07;

   state_t      state_q, state_d;
   logic [31:0] instr_q, pc_q, a_q, res_q, npc_q;
   logic [16:0] addr_q;
   logic        run_prev;

   logic [5:0]  op;
   logic [4:0]  rd, rs, rt;
   logic [15:0] imm;
   logic [31:0] sext, sum_imm, exec_res, exec_npc;
   logic        accept, writes_reg, pc_wr_en;

   assign op   = instr_q[31:26];
   assign rd   = instr_q[25:21];
   assign rs   = instr_q[20:16];
   assign rt   = instr_q[15:11];
   assign imm  = instr_q[15:0];
   assign sext = {{16{imm[15]}}, imm};

   assign accept     = (state_q == S_IDLE) && bus.run && !run_prev;
   assign writes_reg = (op == OP_ADD) || (op == OP_SUB) || (op == OP_ADDI) || (op == OP_LW);
   assign sum_imm    = a_q + sext;

`ifdef INSTR_EXEC_ILLEGAL_TRAP_EN
   logic op_legal;
   assign op_legal = (op <= OP_JMP);
   assign pc_wr_en = op_legal;

   always_ff @(posedge clk) begin
      if (rst)
         illegal <= 1'b0;
      else if (state_q == S_WB && !op_legal)
         illegal <= 1'b1;
   end
`else
   assign pc_wr_en = 1'b1;
`endif

   // In EXEC the second operand is still on reg_rdata; SW carries the rd value through res_q.
   always_comb begin
      exec_res = bus.reg_rdata;
      exec_npc = pc_q + 32'd1;
      case (op)
         OP_ADD:  exec_res = a_q + bus.reg_rdata;
         OP_SUB:  exec_res = a_q - bus.reg_rdata;
         OP_ADDI: exec_res = sum_imm;
         OP_BEQ:  if (a_q == bus.reg_rdata) exec_npc = pc_q + 32'd1 + sext;
         OP_JMP:  exec_npc = {16'b0, imm};
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   // run_prev resets high so a run level held through reset needs a fresh 0->1 edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_prev <= 1'b1;
         instr_q  <= '0;
         pc_q     <= '0;
         a_q      <= '0;
         res_q    <= '0;
         npc_q    <= '0;
         addr_q   <= '0;
      end else begin
         run_prev <= bus.run;
         if (accept) begin
            instr_q <= bus.instr;
            pc_q    <= bus.pc;
         end
         case (state_q)
            S_RD_B:  a_q <= bus.reg_rdata;
            S_EXEC: begin
               res_q  <= exec_res;
               npc_q  <= exec_npc;
               addr_q <= sum_imm[16:0];
            end
            S_MEM_W: res_q <= bus.mem_rdata;
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d       = state_q;
      bus.ok        = 1'b0;
      bus.reg_raddr = '0;
      bus.reg_waddr = '0;
      bus.reg_wdata = '0;
      bus.reg_wren  = 1'b0;
      bus.mem_raddr = '0;
      bus.mem_waddr = '0;
      bus.mem_wdata = '0;
      bus.mem_wren  = 1'b0;
      bus.pc_wdata  = '0;
      bus.pc_wren   = 1'b0;
      unique case (state_q)
         S_IDLE: if (accept) state_d = S_RD_A;
         S_RD_A: begin
            bus.reg_raddr = rs;
            state_d       = S_RD_B;
         end
         S_RD_B: begin
            bus.reg_raddr = (op == OP_ADD || op == OP_SUB) ? rt : rd;
            state_d       = S_EXEC;
         end
         S_EXEC:  state_d = (op == OP_LW) ? S_MEM : S_WB;
         S_MEM: begin
            bus.mem_raddr = addr_q;
            state_d       = S_MEM_W;
         end
         S_MEM_W: state_d = S_WB;
         S_WB: begin
            bus.pc_wren  = pc_wr_en;
            bus.pc_wdata = pc_wr_en ? npc_q : 32'd0;
            if (writes_reg) begin
               bus.reg_wren  = 1'b1;
               bus.reg_waddr = rd;
               bus.reg_wdata = res_q;
            end
            if (op == OP_SW) begin
               bus.mem_wren  = 1'b1;
               bus.mem_waddr = addr_q;
               bus.mem_wdata = res_q;
            end
            state_d = S_DONE;
         end
         S_DONE: begin
            bus.ok  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end
endmodule

// File: tb/tb_instr_executor.sv
// tb/tb_instr_executor.sv - scoreboard bench for instr_executor with a behavioural instruction model
module tb_instr_executor;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   instr_executor_if bus();
`ifdef INSTR_EXEC_ILLEGAL_TRAP_EN
   logic illegal;
   instr_executor dut (.clk(clk), .rst(rst), .illegal(illegal), .bus(bus));
`else
   instr_executor dut (.clk(clk), .rst(rst), .bus(bus));
`endif

   typedef struct {
      logic        pc_en;
      logic [31:0] pc_w;
      logic        reg_en;
      logic [4:0]  reg_a;
      logic [31:0] reg_d;
      logic        mem_en;
      logic [16:0] mem_a;
      logic [31:0] mem_d;
      logic        ill;
      int          lat;
      int          acc;
   } exp_t;

   exp_t        q[$];
   logic [31:0] rf [32];
   logic [31:0] mem_store [logic [16:0]];
   int          cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;
   int          ok_events = 0;
   int          wren_events = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_read(input logic [16:0] a);
      if (mem_store.exists(a)) return mem_store[a];
      return 32'h9E3779B9 * {15'b0, a} + 32'h01234567;
   endfunction

   // Responders: registered read data, one cycle after the address.
   always @(posedge clk) begin
      bus.reg_rdata <= rf[bus.reg_raddr];
      bus.mem_rdata <= mem_read(bus.mem_raddr);
   end

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: the architectural effect of one instruction on the bench's register/memory state.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] p);
      exp_t        e;
      logic [5:0]  op  = ins[31:26];
      logic [4:0]  rd  = ins[25:21];
      logic [31:0] a   = rf[ins[20:16]];
      logic [31:0] sx  = {{16{ins[15]}}, ins[15:0]};
      logic [31:0] ea  = a + sx;
      e = '{pc_en: 1'b1, pc_w: p + 32'd1, reg_en: 1'b0, reg_a: rd, reg_d: 32'd0,
            mem_en: 1'b0, mem_a: ea[16:0], mem_d: 32'd0, ill: 1'b0, lat: 4, acc: 0};
      case (op)
         6'h01: begin e.reg_en = 1'b1; e.reg_d = a + rf[ins[15:11]]; end
         6'h02: begin e.reg_en = 1'b1; e.reg_d = a - rf[ins[15:11]]; end
         6'h03: begin e.reg_en = 1'b1; e.reg_d = ea; end
         6'h04: begin e.reg_en = 1'b1; e.reg_d = mem_read(ea[16:0]); e.lat = 6; end
         6'h05: begin e.mem_en = 1'b1; e.mem_d = rf[rd]; end
         6'h06: if (a == rf[rd]) e.pc_w = p + 32'd1 + sx;
         6'h07: e.pc_w = {16'b0, ins[15:0]};
         6'h00: ;
         default: begin
`ifdef INSTR_EXEC_ILLEGAL_TRAP_EN
            e.pc_en = 1'b0;
            e.ill   = 1'b1;
`endif
         end
      endcase
      return e;
   endfunction

   // Monitor: collects writes, then scores them against the queued expectation when ok pulses.
   logic        s_pc, s_reg, s_mem;
   logic [31:0] v_pc, v_reg_d, v_mem_d;
   logic [4:0]  v_reg_a;
   logic [16:0] v_mem_a;
   int          c_pc, c_reg, c_mem;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         s_pc = 0; s_reg = 0; s_mem = 0;
      end else begin
         if (bus.pc_wren || bus.reg_wren || bus.mem_wren) wren_events++;
         if (bus.pc_wren)  begin s_pc = 1; v_pc = bus.pc_wdata; c_pc = cyc; end
         if (bus.reg_wren) begin s_reg = 1; v_reg_a = bus.reg_waddr; v_reg_d = bus.reg_wdata; c_reg = cyc; end
         if (bus.mem_wren) begin s_mem = 1; v_mem_a = bus.mem_waddr; v_mem_d = bus.mem_wdata; c_mem = cyc; end
         if (bus.ok) begin
            ok_events++;
            if (q.size() == 0) begin
               chk("unexpected_ok", 1, 0);
            end else begin
               e = q.pop_front();
               chk("latency", 64'(cyc - e.acc), 64'(e.lat));
               chk("pc_wren", s_pc, e.pc_en);
               if (s_pc && e.pc_en) begin
                  chk("pc_wdata", v_pc, e.pc_w);
                  chk("pc_wren_timing", 64'(cyc - c_pc), 1);
               end
               chk("reg_wren", s_reg, e.reg_en);
               if (s_reg && e.reg_en) begin
                  chk("reg_waddr", v_reg_a, e.reg_a);
                  chk("reg_wdata", v_reg_d, e.reg_d);
                  chk("reg_wren_timing", 64'(cyc - c_reg), 1);
               end
               chk("mem_wren", s_mem, e.mem_en);
               if (s_mem && e.mem_en) begin
                  chk("mem_waddr", v_mem_a, e.mem_a);
                  chk("mem_wdata", v_mem_d, e.mem_d);
                  chk("mem_wren_timing", 64'(cyc - c_mem), 1);
               end
`ifdef INSTR_EXEC_ILLEGAL_TRAP_EN
               if (e.ill) chk("illegal", illegal, 1);
`endif
            end
            s_pc = 0; s_reg = 0; s_mem = 0;
         end
      end
   end

   task automatic do_op(input logic [31:0] ins, input logic [31:0] p, input int hold);
      exp_t e;
      int   budget;
      @(posedge clk); #1;
      e     = model(ins, p);
      e.acc = cyc + 1;
      q.push_back(e);
      bus.instr = ins;
      bus.pc    = p;
      bus.run   = 1'b1;
      budget    = 0;
      do begin
         @(negedge clk);
         budget++;
      end while (!bus.ok && budget < 30);
      if (!bus.ok) begin
         chk("ok_timeout", 0, 1);
         q.delete();
      end
      if (e.reg_en) rf[e.reg_a] = e.reg_d;
      if (e.mem_en) mem_store[e.mem_a] = e.mem_d;
      repeat (hold) @(posedge clk);
      @(posedge clk); #1;
      bus.run   = 1'b0;
      bus.instr = $urandom;
      bus.pc    = $urandom;
      @(posedge clk);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_ok"}, bus.ok, 0);
      chk({tag, "_wrens"}, {bus.reg_wren, bus.mem_wren, bus.pc_wren}, 0);
      chk({tag, "_raddrs"}, {bus.reg_raddr, bus.mem_raddr}, 0);
      chk({tag, "_wdata"}, {bus.reg_wdata, bus.pc_wdata}, 0);
      chk({tag, "_waddrs_mem_wdata"}, {bus.reg_waddr, bus.mem_waddr, bus.mem_wdata}, 0);
   endtask

   initial begin
      int ok0, wr0;
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      rst       = 1'b1;
      bus.run   = 1'b1;
      bus.instr = {6'h01, 5'd3, 5'd1, 5'd2, 11'd0};
      bus.pc    = 32'd10;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_idle_outputs("reset");
      @(posedge clk); #1;
      rst = 1'b0;
      ok0 = ok_events;
      repeat (8) @(posedge clk);
      @(negedge clk);
      chk("held_run_after_reset_no_accept", 64'(ok_events - ok0), 0);
      chk("held_run_after_reset_raddr", bus.reg_raddr, 0);
      @(posedge clk); #1;
      bus.run = 1'b0;

      rf[1] = 32'd5; rf[2] = 32'hFFFFFFFE;
      do_op({6'h01, 5'd3, 5'd1, 5'd2, 11'd0}, 32'd10, 0);
      rf[1] = 32'd0; mem_store[17'h1FFFF] = 32'hDEADBEEF;
      do_op({6'h04, 5'd4, 5'd1, 16'hFFFF}, 32'd30, 0);
      rf[1] = 32'h100; rf[6] = 32'h55;
      do_op({6'h05, 5'd6, 5'd1, 16'd4}, 32'd40, 0);
      rf[7] = 32'd9; rf[8] = 32'd9;
      do_op({6'h06, 5'd7, 5'd8, 16'hFFFD}, 32'd20, 0);
      rf[7] = 32'd10;
      do_op({6'h06, 5'd7, 5'd8, 16'hFFFD}, 32'd20, 0);
      do_op({6'h07, 10'd0, 16'h1234}, 32'd50, 0);
      do_op({6'h3F, 26'h155AAAA}, 32'd60, 0);

      ok0 = ok_events;
      do_op({6'h00, 26'd0}, 32'd70, 6);
      chk("run_held_no_second_op", 64'(ok_events - ok0), 1);

      // Abort in EXEC: accept edge, RD_A->RD_B, RD_B->EXEC, then reset.
      @(posedge clk); #1;
      bus.instr = {6'h01, 5'd9, 5'd1, 5'd2, 11'd0};
      bus.run   = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      ok0 = ok_events;
      wr0 = wren_events;
      @(posedge clk); #1;
      rst     = 1'b0;
      bus.run = 1'b0;
      @(negedge clk);
      check_idle_outputs("abort");
      repeat (8) @(posedge clk);
      chk("abort_no_wren", 64'(wren_events - wr0), 0);
      chk("abort_no_ok", 64'(ok_events - ok0), 0);

      for (int n = 0; n < 150; n++) begin
         logic [31:0] ins;
         logic [5:0]  op;
         op  = ($urandom_range(0, 9) == 9) ? 6'($urandom_range(8, 63)) : 6'($urandom_range(0, 7));
         ins = {op, 26'($urandom)};
         if (op == 6'h06 && $urandom_range(0, 1) == 1) rf[ins[25:21]] = rf[ins[20:16]];
         if ($urandom_range(0, 3) == 0) rf[$urandom_range(0, 31)] = $urandom;
         do_op(ins, $urandom, $urandom_range(0, 2));
      end

      repeat (4) @(posedge clk);
      chk("scoreboard_drained", 64'(q.size()), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
